turn_signal_ctrl: RTL and testbench

- Sequences the left and right 3-lamp tail-light sequencers. Each sequencer is an enable-driven FSM: lamps step 000 -> 001 -> 011 -> 111 -> 001 ..., and it returns to 000 when its enable drops.
- Arbitrates the driver's left, right and hazard requests into one mode, and drives each sequencer's enable.
- Generates the hazard flash pattern itself and muxes the final lamp outputs.
- Sits between the switch inputs and the two sequencer instances at the top level.

---
 rtl/turn_signal_ctrl.sv | 138 +++++++++++++
 tb/tb_turn_signal_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl
//   Arbitrates left / right / hazard switch requests into one lamp mode,
//   enables the left and right 3-lamp sequencers, generates the hazard
//   flash itself and muxes the final lamp drive. Every output is registered.
//
// Parameters
//   HALF_PERIOD  clock ticks per hazard on or off phase
//   CNT_W        hazard phase counter width (must hold HALF_PERIOD)
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   left_req/right_req           turn switches (level, already synchronised)
//   hazard_req                   hazard switch (level)
//   left_seq_leds/right_seq_leds lamp patterns from the two sequencers
//   left_ena/right_ena           sequencer enables
//   left_leds/right_leds         final lamp drive
//   mode                         current state encoding (debug / status)
//   brake                        brake pedal, present only with BRAKE_LAMP_EN
//
// Build option
//   BRAKE_LAMP_EN  adds the brake input; brake lights every lamp group not
//                  owned by an active turn signal (both sides during hazard).
module turn_signal_ctrl #(
  parameter int HALF_PERIOD = 500,
  parameter int CNT_W       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
`ifdef BRAKE_LAMP_EN
  input  logic       brake,
`endif
  input  logic [2:0] left_seq_leds,
  input  logic [2:0] right_seq_leds,
  output logic       left_ena,
  output logic       right_ena,
  output logic [2:0] left_leds,
  output logic [2:0] right_leds,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    LEFT    = 3'b001,
    RIGHT   = 3'b010,
    GAP     = 3'b011,
    HAZ_ON  = 3'b100,
    HAZ_OFF = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       l_nxt, r_nxt;

  logic left_only, right_only, no_req;
  assign left_only  = left_req  & ~right_req;
  assign right_only = right_req & ~left_req;
  assign no_req     = ~left_req & ~right_req;

  assign mode = state;

  always_comb begin
    nxt     = IDLE;
    cnt_nxt = '0;
    case (state)
      // GAP decodes like IDLE; its one-cycle dwell with both enables low
      // lets the outgoing sequencer fall back to 000 before the new one starts.
      IDLE, GAP: begin
        if (hazard_req)      nxt = HAZ_ON;
        else if (left_only)  nxt = LEFT;
        else if (right_only) nxt = RIGHT;
        else                 nxt = IDLE;
      end
      LEFT: begin
        if (hazard_req || right_only) nxt = GAP;
        else if (no_req)              nxt = IDLE;
        else                          nxt = LEFT;   // left only, or conflict: hold
      end
      RIGHT: begin
        if (hazard_req || left_only) nxt = GAP;
        else if (no_req)             nxt = IDLE;
        else                         nxt = RIGHT;
      end
      HAZ_ON, HAZ_OFF: begin
        if (!hazard_req) begin
          nxt = IDLE;
        end else if (cnt >= CNT_LAST) begin
          nxt = (state == HAZ_ON) ? HAZ_OFF : HAZ_ON;
        end else begin
          nxt     = state;
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Lamp mux works from the next state so lamps move on the same edge as mode.
  always_comb begin
    l_nxt = 3'b000;
    r_nxt = 3'b000;
    case (nxt)
      LEFT:    l_nxt = left_seq_leds;
      RIGHT:   r_nxt = right_seq_leds;
      HAZ_ON:  begin l_nxt = 3'b111; r_nxt = 3'b111; end
      default: ;
    endcase
`ifdef BRAKE_LAMP_EN
    if (brake) begin
      if (nxt != LEFT)  l_nxt = 3'b111;
      if (nxt != RIGHT) r_nxt = 3'b111;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      left_ena   <= 1'b0;
      right_ena  <= 1'b0;
      left_leds  <= 3'b000;
      right_leds <= 3'b000;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      left_ena   <= (nxt == LEFT);
      right_ena  <= (nxt == RIGHT);
      left_leds  <= l_nxt;
      right_leds <= r_nxt;
    end
  end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
module tb_turn_signal_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       left_req, right_req, hazard_req;
  logic       brake;
  logic [2:0] lseq, rseq;
  logic       left_ena, right_ena;
  logic [2:0] left_leds, right_leds, mode;
  logic [2:0] exp_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_signal_ctrl #(.HALF_PERIOD(500), .CNT_W(9)) dut (
    .clk            (clk),
    .rst            (rst),
    .left_req       (left_req),
    .right_req      (right_req),
    .hazard_req     (hazard_req),
`ifdef BRAKE_LAMP_EN
    .brake          (brake),
`endif
    .left_seq_leds  (lseq),
    .right_seq_leds (rseq),
    .left_ena       (left_ena),
    .right_ena      (right_ena),
    .left_leds      (left_leds),
    .right_leds     (right_leds),
    .mode           (mode)
  );

  // Sequencer model: 000 -> 001 -> 011 -> 111 -> 001 ..., back to 000 when disabled.
  function automatic logic [2:0] seq_step(input logic [2:0] s);
    case (s)
      3'b000:  return 3'b001;
      3'b001:  return 3'b011;
      3'b011:  return 3'b111;
      default: return 3'b001;
    endcase
  endfunction

  always @(posedge clk) begin
    lseq <= left_ena  ? seq_step(lseq) : 3'b000;
    rseq <= right_ena ? seq_step(rseq) : 3'b000;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    chk("no_overlap", {31'd0, left_ena & right_ena}, 32'd0);
  endtask

  task automatic chk_mode(input string tag, input logic [2:0] m, input logic le,
                          input logic re, input logic [2:0] ll, input logic [2:0] rl);
    chk({tag, "_mode"}, {29'd0, mode}, {29'd0, m});
    chk({tag, "_lena"}, {31'd0, left_ena}, {31'd0, le});
    chk({tag, "_rena"}, {31'd0, right_ena}, {31'd0, re});
    chk({tag, "_lleds"}, {29'd0, left_leds}, {29'd0, ll});
    chk({tag, "_rleds"}, {29'd0, right_leds}, {29'd0, rl});
  endtask

  initial begin
    rst = 1'b0; left_req = 1'b1; right_req = 1'b1; hazard_req = 1'b1; brake = 1'b0;
    lseq = 3'b000; rseq = 3'b000;

    // Reset with every request asserted
    repeat (3) tick();
    chk_mode("reset", 3'b000, 0, 0, 3'b000, 3'b000);
    rst = 1'b1;
    tick();
    chk_mode("rst_rel_haz", 3'b100, 0, 0, 3'b111, 3'b111);
    hazard_req = 1'b0; left_req = 1'b0; right_req = 1'b0;
    tick();
    chk_mode("haz_drop", 3'b000, 0, 0, 3'b000, 3'b000);

    // Left turn with sequencer attached
    left_req = 1'b1;
    tick();
    chk_mode("left_enter", 3'b001, 1, 0, 3'b000, 3'b000);
    for (int i = 0; i < 2000; i++) begin
      exp_l = lseq;
      tick();
      chk("left_track", {29'd0, left_leds}, {29'd0, exp_l});
      if (i < 8 || i % 100 == 0) begin
        chk("left_rleds", {29'd0, right_leds}, 32'd0);
        chk("left_ena_hold", {31'd0, left_ena}, 32'd1);
      end
    end
    // Conflict while in LEFT holds LEFT
    right_req = 1'b1;
    tick();
    chk("left_conflict", {29'd0, mode}, 32'd1);
    right_req = 1'b0; left_req = 1'b0;
    tick();
    chk_mode("left_drop", 3'b000, 0, 0, 3'b000, 3'b000);

    // Direction switch LEFT -> GAP -> RIGHT
    left_req = 1'b1;
    tick(); tick();
    left_req = 1'b0; right_req = 1'b1;
    tick();
    chk_mode("switch_gap", 3'b011, 0, 0, 3'b000, 3'b000);
    tick();
    chk_mode("switch_right", 3'b010, 0, 1, 3'b000, 3'b000);

    // Conflict from RIGHT: hold RIGHT
    left_req = 1'b1;
    tick();
    chk("right_conflict1", {29'd0, mode}, 32'd2);
    tick();
    chk("right_conflict2", {29'd0, mode}, 32'd2);
    chk("right_conf_ena", {31'd0, right_ena}, 32'd1);

    // Conflict from IDLE: stay IDLE
    left_req = 1'b0; right_req = 1'b0;
    tick();
    chk("idle_again", {29'd0, mode}, 32'd0);
    left_req = 1'b1; right_req = 1'b1;
    tick();
    chk_mode("idle_conflict1", 3'b000, 0, 0, 3'b000, 3'b000);
    tick();
    chk("idle_conflict2", {29'd0, mode}, 32'd0);

    // Hazard: 4 periods of 500 on / 500 off, turn requests ignored
    hazard_req = 1'b1;
    tick();
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 500; i++) begin
        if (i == 0 || i == 499 || i % 50 == 0) begin
          chk("haz_mode", {29'd0, mode}, (ph % 2 == 0) ? 32'd4 : 32'd5);
          chk("haz_ena", {30'd0, left_ena, right_ena}, 32'd0);
        end
        chk("haz_lleds", {29'd0, left_leds}, (ph % 2 == 0) ? 32'd7 : 32'd0);
        chk("haz_rleds", {29'd0, right_leds}, (ph % 2 == 0) ? 32'd7 : 32'd0);
        tick();
      end
    end
    // Now first cycle of a new HAZ_ON with counter 0; run to counter 237
    repeat (237) tick();
    chk("haz_mid", {29'd0, mode}, 32'd4);
    hazard_req = 1'b0; left_req = 1'b0; right_req = 1'b0;
    tick();
    chk_mode("haz_mid_drop", 3'b000, 0, 0, 3'b000, 3'b000);
    // Re-entry: full 500-cycle HAZ_ON proves the counter restarted at 0
    hazard_req = 1'b1;
    tick();
    chk_mode("haz_reenter", 3'b100, 0, 0, 3'b111, 3'b111);
    repeat (499) tick();
    chk("haz_reenter_last", {29'd0, mode}, 32'd4);
    tick();
    chk_mode("haz_reenter_off", 3'b101, 0, 0, 3'b000, 3'b000);
    hazard_req = 1'b0;
    tick();
    chk("haz_off_drop", {29'd0, mode}, 32'd0);

`ifdef BRAKE_LAMP_EN
    brake = 1'b1;
    tick();
    chk_mode("brake_idle", 3'b000, 0, 0, 3'b111, 3'b111);
    brake = 1'b0; left_req = 1'b1;
    tick(); tick(); tick();
    brake = 1'b1;
    exp_l = lseq;
    tick();
    chk_mode("brake_left", 3'b001, 1, 0, exp_l, 3'b111);
    brake = 1'b0; left_req = 1'b0; hazard_req = 1'b1;
    tick(); // GAP
    tick(); // HAZ_ON
    repeat (500) tick();
    chk("brake_hoff_pre", {29'd0, left_leds}, 32'd0);
    brake = 1'b1;
    tick();
    chk_mode("brake_hazoff", 3'b101, 0, 0, 3'b111, 3'b111);
    brake = 1'b0; hazard_req = 1'b0;
    tick();
`endif

    // Reset mid-operation
    left_req = 1'b1;
    tick();
    chk("pre_reset_left", {29'd0, mode}, 32'd1);
    rst = 1'b0;
    tick();
    chk_mode("mid_reset", 3'b000, 0, 0, 3'b000, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
